// File: rtl/tile_select_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : tile_select_sequencer_if
// Description : Request handshake and tile-select bus between a host-side
//               requester and the tile select sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
interface tile_select_sequencer_if #(
    parameter int SEL_W = 2
);
    logic             req_valid;
    logic [SEL_W-1:0] req_sel;
    logic             req_ready;
    logic [SEL_W-1:0] sel_out;
    logic             tile_rst_n;
    logic             tile_clk_en;
    logic             busy;
    logic             done;
    logic             err;

    // Requester side: issues requests, observes the tile controls.
    modport master (
        output req_valid, req_sel,
        input  req_ready, sel_out, tile_rst_n, tile_clk_en, busy, done, err
    );

    // Sequencer side: accepts requests, drives the tile controls.
    modport slave (
        input  req_valid, req_sel,
        output req_ready, sel_out, tile_rst_n, tile_clk_en, busy, done, err
    );
endinterface
`default_nettype wire

// File: rtl/tile_select_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tile_select_sequencer
// Description : Turns a one-shot tile select request into a glitch-safe
//               switch: reset old tile, gate clock, change sel, settle,
//               ungate clock, reset new tile, release.
// Revision    : 1.0 - initial release
// ============================================================================
module tile_select_sequencer #(
    parameter int NUM_TILES     = 4,
    parameter int SEL_W         = 2,
    parameter int RESET_CYCLES  = 8,
    parameter int SETTLE_CYCLES = 4
) (
    input  wire logic              clk,
    input  wire logic              rst,
    tile_select_sequencer_if.slave bus
);

    localparam int MAX_CYCLES = (RESET_CYCLES > SETTLE_CYCLES) ? RESET_CYCLES : SETTLE_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES) + 1;

    localparam logic [CNT_W-1:0] RST_LOAD    = CNT_W'(RESET_CYCLES);
    localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST    = CNT_W'(1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ASSERT  = 3'd1,
        S_GATE    = 3'd2,
        S_SWITCH  = 3'd3,
        S_WAKE    = 3'd4,
        S_RELEASE = 3'd5
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;       // cycles remaining in the current counted state
    logic [SEL_W-1:0]   tgt_q, tgt_d;       // latched target tile
    logic [SEL_W-1:0]   sel_out_q, sel_out_d;
    logic               tile_rst_n_q, tile_rst_n_d;
    logic               tile_clk_en_q, tile_clk_en_d;
    logic               busy_q, busy_d;
    logic               req_ready_q, req_ready_d;
    logic               done_q, done_d;
    logic               err_q, err_d;
    logic               w_in_range;

    // Widened compare so a fully populated select space does not fold to a constant.
    assign w_in_range = (32'(bus.req_sel) < 32'(NUM_TILES));

    // Next state, counter and the registered output values of the state being entered.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        tgt_d     = tgt_q;
        sel_out_d = sel_out_q;
        err_d     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.req_valid) begin
                    if (w_in_range) begin
                        state_d = S_ASSERT;
                        cnt_d   = RST_LOAD;
                        tgt_d   = bus.req_sel;
                    end else begin
                        err_d   = 1'b1;
                    end
                end
            end
            S_ASSERT: begin
                if (cnt_q == CNT_LAST) state_d = S_GATE;
                else                   cnt_d   = cnt_q - CNT_LAST;
            end
            S_GATE: begin
                // Clock is already stopped here, so sel may move on this edge.
                state_d   = S_SWITCH;
                cnt_d     = SETTLE_LOAD;
                sel_out_d = tgt_q;
            end
            S_SWITCH: begin
                if (cnt_q == CNT_LAST) begin
                    state_d = S_WAKE;
                    cnt_d   = RST_LOAD;
                end else begin
                    cnt_d   = cnt_q - CNT_LAST;
                end
            end
            S_WAKE: begin
                if (cnt_q == CNT_LAST) state_d = S_RELEASE;
                else                   cnt_d   = cnt_q - CNT_LAST;
            end
            S_RELEASE: state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase

        tile_rst_n_d  = (state_d == S_IDLE) || (state_d == S_RELEASE);
        tile_clk_en_d = (state_d != S_GATE) && (state_d != S_SWITCH);
        busy_d        = (state_d != S_IDLE);
        req_ready_d   = (state_d == S_IDLE);
        done_d        = (state_d == S_RELEASE);
    end

    // State and output registers; reset lands in WAKE so the boot tile gets a full reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_WAKE;
            cnt_q         <= RST_LOAD;
            tgt_q         <= '0;
            sel_out_q     <= '0;
            tile_rst_n_q  <= 1'b0;
            tile_clk_en_q <= 1'b1;
            busy_q        <= 1'b1;
            req_ready_q   <= 1'b0;
            done_q        <= 1'b0;
            err_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            tgt_q         <= tgt_d;
            sel_out_q     <= sel_out_d;
            tile_rst_n_q  <= tile_rst_n_d;
            tile_clk_en_q <= tile_clk_en_d;
            busy_q        <= busy_d;
            req_ready_q   <= req_ready_d;
            done_q        <= done_d;
            err_q         <= err_d;
        end
    end

    assign bus.sel_out     = sel_out_q;
    assign bus.tile_rst_n  = tile_rst_n_q;
    assign bus.tile_clk_en = tile_clk_en_q;
    assign bus.busy        = busy_q;
    assign bus.req_ready   = req_ready_q;
    assign bus.done        = done_q;
    assign bus.err         = err_q;

endmodule
`default_nettype wire
